// File: rtl/egress_arb.sv
// egress_arb: round-robin arbiter that moves fixed-length block packets from NUM_PORTS requesters to one egress.
// Defining EGRESS_ARB_STATS_EN adds saturating statistics counters readable through stat_sel/stat_out.
module egress_arb #(
   parameter int NUM_PORTS       = 4,
   parameter int PACKET_XFER_LEN = 32,
   parameter int PACKET_BLOCKS   = 8,
   parameter int GAP_CYCLES      = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_PORTS-1:0]                 req,
   input  logic [NUM_PORTS*PACKET_XFER_LEN-1:0] data_in,
   input  logic                                 egress_full,
   output logic [NUM_PORTS-1:0]                 grant,
   output logic [NUM_PORTS-1:0]                 pop,
   output logic                                 write_en,
   output logic [PACKET_XFER_LEN-1:0]           data_out,
   output logic                                 busy,
   input  logic [2:0]                           stat_sel,
   output logic [15:0]                          stat_out
);
   localparam int         PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [7:0] LAST_BEAT = 8'(PACKET_BLOCKS - 1);
   localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t        state;
   logic [PW-1:0] last_winner;
   logic [PW-1:0] next_winner;
   logic [7:0]    beat_cnt;
   logic [3:0]    gap_cnt;
   logic          any_pop;

   // First requester strictly after the previous winner, wrapping naturally in PW bits.
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                             input logic [PW-1:0] last);
      logic [PW-1:0] idx;
      logic          found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = last + PW'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign next_winner = rr_pick(req, last_winner);
   assign pop         = (state == XFER && !egress_full) ? (grant & req) : '0;
   assign any_pop     = |pop;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         write_en    <= 1'b0;
         data_out    <= '0;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         last_winner <= PW'(NUM_PORTS - 1);
      end else begin
         write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  grant       <= NUM_PORTS'(1) << next_winner;
                  last_winner <= next_winner;
                  beat_cnt    <= '0;
                  state       <= XFER;
               end
            end
            XFER: begin
               // last_winner is the owner for the whole packet, so it selects the data slice.
               if (any_pop) begin
                  write_en <= 1'b1;
                  data_out <= data_in[int'(last_winner)*PACKET_XFER_LEN +: PACKET_XFER_LEN];
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_cnt == LAST_BEAT) begin
                     grant   <= '0;
                     gap_cnt <= GAP_LOAD;
                     state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - 4'd1;
               if (gap_cnt == 4'd1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EGRESS_ARB_STATS_EN
   logic [15:0] port_pkts [NUM_PORTS];
   logic [15:0] stall_cnt;
   logic [15:0] total_pkts;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) port_pkts[i] <= '0;
         stall_cnt  <= '0;
         total_pkts <= '0;
      end else begin
         if (state == IDLE && |req) begin
            port_pkts[next_winner] <= sat_inc(port_pkts[next_winner]);
            total_pkts             <= sat_inc(total_pkts);
         end
         if (state == XFER && !any_pop) stall_cnt <= sat_inc(stall_cnt);
      end
   end

   // Selects 6 and 7 take precedence over per-port counters when NUM_PORTS is 8.
   always_comb begin
      stat_out = '0;
      if (stat_sel == 3'd6)                 stat_out = stall_cnt;
      else if (stat_sel == 3'd7)            stat_out = total_pkts;
      else if (int'(stat_sel) < NUM_PORTS)  stat_out = port_pkts[stat_sel[PW-1:0]];
   end
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_out        = '0;
`endif

endmodule

// File: tb/tb_egress_arb.sv
// tb_egress_arb: randomized and directed scoreboard bench for egress_arb with a packet-level reference model.
`timescale 1ns/1ps
module tb_egress_arb;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int BLK = 8;
   localparam int GAP = 2;

   logic           clk   = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req;
   logic [N*W-1:0] data_in;
   logic           egress_full;
   logic [N-1:0]   grant;
   logic [N-1:0]   pop;
   logic           write_en;
   logic [W-1:0]   data_out;
   logic           busy;
   logic [2:0]     stat_sel;
   logic [15:0]    stat_out;

   egress_arb #(.NUM_PORTS(N), .PACKET_XFER_LEN(W), .PACKET_BLOCKS(BLK), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset(reset), .req(req), .data_in(data_in), .egress_full(egress_full),
      .grant(grant), .pop(pop), .write_en(write_en), .data_out(data_out), .busy(busy),
      .stat_sel(stat_sel), .stat_out(stat_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Block payload: {port+1, packet number, beat number}; port 0 packet 0 gives 0x1000_0000+k.
   function automatic logic [W-1:0] enc(input int p, input int pkt, input int b);
      return {4'(p + 1), 12'(pkt), 16'(b)};
   endfunction

   // Requester sources
   int         pending [N];
   int         src_pkt [N];
   int         src_beat[N];
   bit         full_force = 0;
   bit         rand_en    = 0;
   bit         rnd_full   = 0;
   logic [N-1:0] drop  = '0;
   logic [N-1:0] pop_s = '0;

   initial begin
      for (int i = 0; i < N; i++) begin
         pending[i] = 0; src_pkt[i] = 0; src_beat[i] = 0;
      end
      req = '0; data_in = '0; egress_full = 1'b0; stat_sel = 3'd0;
      forever begin
         @(negedge clk);
         pop_s = pop;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (pop_s[i]) begin
               src_beat[i]++;
               if (src_beat[i] == BLK) begin
                  src_beat[i] = 0;
                  src_pkt[i]++;
                  if (pending[i] > 0) pending[i]--;
               end
            end
         end
         if (rand_en) begin
            for (int i = 0; i < N; i++) begin
               if (pending[i] < 2 && $urandom_range(0, 15) == 0) pending[i]++;
               drop[i] = ($urandom_range(0, 7) == 0);
            end
            rnd_full = ($urandom_range(0, 3) == 0);
         end else begin
            drop     = '0;
            rnd_full = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            req[i]            = (pending[i] > 0) && !drop[i];
            data_in[i*W +: W] = enc(i, src_pkt[i], src_beat[i]);
         end
         egress_full = full_force | rnd_full;
      end
   end

   // Reference model: owner / beats-done / gap-remaining view of a packet, with round-robin choice.
   int           m_owner = -1;
   int           m_done  = 0;
   int           m_gap   = 0;
   int           m_last  = N - 1;
   int           m_pkt[N];
   logic [W-1:0] exp_q[$];
   bit           exp_we = 0;

   initial begin
      for (int i = 0; i < N; i++) m_pkt[i] = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_owner = -1; m_gap = 0; m_last = N - 1; exp_we = 0;
            exp_q.delete();
         end else begin
            logic [N-1:0] eg;
            logic [N-1:0] ep;
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            ep = (m_owner >= 0 && req[m_owner] && !egress_full) ? eg : '0;
            check("grant", grant, eg);
            check("pop", pop, ep);
            check("busy", busy, (m_owner >= 0 || m_gap > 0));
            check("write_en", write_en, exp_we);
            exp_we = 0;
            if (m_owner >= 0) begin
               if (ep != '0) begin
                  exp_q.push_back(enc(m_owner, m_pkt[m_owner], m_done));
                  exp_we = 1;
                  m_done++;
                  if (m_done == BLK) begin
                     m_pkt[m_owner]++;
                     m_owner = -1;
                     m_gap   = GAP;
                  end
               end
            end else if (m_gap > 0) begin
               m_gap--;
            end else if (req != '0) begin
               for (int off = 1; off <= N; off++)
                  if (m_owner < 0 && req[(m_last + off) % N]) m_owner = (m_last + off) % N;
               m_last = m_owner;
               m_done = 0;
            end
         end
      end
   end

   // Monitor: consumes expected beats whenever the DUT presents one.
   int           n_we = 0;
   int           gorder[$];
   logic [N-1:0] prev_grant = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_grant = '0;
         end else begin
            if (write_en) begin
               n_we++;
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL beat_q: write_en with data %0h, required no beat", data_out);
               end else begin
                  check("data_out", data_out, exp_q.pop_front());
               end
            end
            if (grant != '0 && prev_grant == '0)
               for (int i = 0; i < N; i++) if (grant[i]) gorder.push_back(i);
            prev_grant = grant;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   function automatic bit any_pending();
      bit r = 0;
      for (int i = 0; i < N; i++) if (pending[i] > 0) r = 1;
      return r;
   endfunction

   task automatic wait_idle(input int lim);
      int c = 0;
      while ((any_pending() || busy) && c < lim) begin
         tick();
         c++;
      end
      check("drain_in_time", (c < lim), 1'b1);
   endtask

   task automatic wait_beats(input int n);
      int start = n_we;
      int c     = 0;
      while (n_we - start < n && c < 100) begin
         tick();
         c++;
      end
      check("beats_in_time", (c < 100), 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_beat[i] = 0; pending[i] = 0;
      end
      tick();
      tick();
      reset = 1'b1;
      gorder.delete();
   endtask

   task automatic check_order(input string name, input int exp_ord[$]);
      check({name, "_len"}, gorder.size(), exp_ord.size());
      for (int i = 0; i < exp_ord.size(); i++)
         check(name, (i < gorder.size()) ? gorder[i] : -1, exp_ord[i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      tick();
      tick();
      check("rst_grant", grant, '0);
      check("rst_we", write_en, 1'b0);
      check("rst_data", data_out, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_pop", pop, '0);
      check("rst_stat", stat_out, '0);
      reset = 1'b1;
      tick();

      // Single packet on port 0: latency, order, gap length
      pending[0] = 1;
      tick();
      check("idle_grant", grant, '0);
      tick();
      check("first_grant", grant, 4'b0001);
      check("first_we", write_en, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            check("lat_we", write_en, 1'b1);
            check("lat_data", data_out, 32'h1000_0000);
         end
         if (k == 9)  check("busy_in_gap", busy, 1'b1);
         if (k == 10) check("busy_end", busy, 1'b0);
      end
      wait_idle(50);

      // All ports requesting after reset
      do_reset();
      pending[0] = 2; pending[1] = 1; pending[2] = 1; pending[3] = 1;
      wait_idle(300);
      check_order("rr_order", '{0, 1, 2, 3, 0});

      // Back-pressure for 3 cycles at beat 4
      gorder.delete();
      start = n_we;
      pending[3] = 1;
      wait_beats(4);
      full_force = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_pop", pop, '0);
      end
      full_force = 0;
      wait_idle(100);
      check("stall_beats", n_we - start, 8);

      // No pre-emption of owner port 2
      gorder.delete();
      pending[2] = 1;
      wait_beats(2);
      pending[0] = 1;
      tick();
      check("hold_grant", grant, 4'b0100);
      wait_idle(100);
      check_order("preempt_order", '{2, 0});

      // Asynchronous reset in beat 3
      pending[2] = 1;
      wait_beats(3);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_grant", grant, '0);
      check("async_we", write_en, 1'b0);
      check("async_busy", busy, 1'b0);
      pending[2] = 0;
      for (int i = 0; i < N; i++) src_beat[i] = 0;
      tick();
      tick();
      reset = 1'b1;
      gorder.delete();
      start = n_we;
      pending[1] = 1;
      wait_idle(100);
      check_order("after_reset_order", '{1});
      check("after_reset_beats", n_we - start, 8);

`ifdef EGRESS_ARB_STATS_EN
      do_reset();
      pending[1] = 3;
      wait_beats(3);
      full_force = 1;
      repeat (5) tick();
      full_force = 0;
      wait_idle(200);
      stat_sel = 3'd1; #1; check("stat_port1", stat_out, 16'd3);
      stat_sel = 3'd6; #1; check("stat_stall", stat_out, 16'd5);
      stat_sel = 3'd7; #1; check("stat_total", stat_out, 16'd3);
      stat_sel = 3'd0; #1; check("stat_port0", stat_out, 16'd0);
      stat_sel = 3'd5; #1; check("stat_unused", stat_out, 16'd0);
`else
      stat_sel = 3'd1; #1; check("stat_off1", stat_out, 16'd0);
      stat_sel = 3'd6; #1; check("stat_off6", stat_out, 16'd0);
      stat_sel = 3'd7; #1; check("stat_off7", stat_out, 16'd0);
`endif
      stat_sel = 3'd0;

      // Randomized traffic, stalls and request drops
      rand_en = 1;
      repeat (1500) tick();
      rand_en = 0;
      wait_idle(600);
      tick();
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
